// File: rtl/ha_event_bank_pkg.sv
// rtl/ha_event_bank_pkg.sv - register offsets, CTRL bit indices and helpers for ha_event_bank
package ha_event_bank_pkg;

  // Register offsets, relative word addresses
  localparam int OFF_CTRL      = 'h000;
  localparam int OFF_INFO      = 'h001;
  localparam int OFF_PTR       = 'h002;
  localparam int OFF_DATA      = 'h003;
  localparam int OFF_SCRATCH   = 'h004;
  localparam int OFF_SNAP_BASE = 'h010;
  localparam int OFF_LIVE_BASE = 'h020;

  // CTRL bit indices
  localparam int CTRL_SNAP    = 0;
  localparam int CTRL_CLR     = 1;
  localparam int CTRL_AUTOINC = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  // Power-up content of RAM word k
  function automatic logic [7:0] ram_init_byte(input logic [7:0] k);
    return 8'h82 + k;
  endfunction

endpackage

// File: rtl/ha_event_counter.sv
// rtl/ha_event_counter.sv - per-channel edge detector, saturating counter and snapshot register
//   clk, rst   : clock, asynchronous active-high reset
//   ev         : event input, synchronous to clk
//   clr, snap  : single-cycle clear / snapshot commands
//   count      : live counter value
//   snap_count : last snapshot
module ha_event_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ev,
  input  logic          clr,
  input  logic          snap,
  output logic [CW-1:0] count,
  output logic [CW-1:0] snap_count
);

  logic          prev;
  logic          rise;
  logic [CW-1:0] bumped;

  assign rise   = ev & ~prev;
  // Saturate rather than wrap at all-ones
  assign bumped = (rise && (count != '1)) ? count + CW'(1) : count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= 1'b0;
      count      <= '0;
      snap_count <= '0;
    end else begin
      prev <= ev;
      // Snapshot sees this cycle's edge; clear drops it
      if (snap) snap_count <= bumped;
      count <= clr ? '0 : bumped;
    end
  end

endmodule

// File: rtl/ha_event_bank.sv
// rtl/ha_event_bank.sv - host-accessible event counter bank with pointer/direct RAM access
//   clk, rst        : clock, asynchronous active-high reset
//   ev[NCHAN]       : event inputs
//   gb_addr/gb_din  : relative word address, write data
//   gb_we/gb_re     : single-cycle write / read strobes
//   gb_dout         : read data, registered one cycle after gb_re, held until next read
module ha_event_bank
  import ha_event_bank_pkg::*;
#(
  parameter int            AW           = 24,
  parameter int            DW           = 32,
  parameter int            NCHAN        = 4,
  parameter int            CW           = 16,
  parameter int            RAMW         = 8,
  parameter int            DEPTH        = 64,
  parameter logic [AW-1:0] RAM_BASE     = 'h100,
  parameter logic [DW-1:0] SCRATCH_INIT = 32'hceceface
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCHAN-1:0] ev,
  input  logic [AW-1:0]    gb_addr,
  input  logic [DW-1:0]    gb_din,
  input  logic             gb_we,
  input  logic             gb_re,
  output logic [DW-1:0]    gb_dout
);

  localparam int PW = clog2(DEPTH);

  logic [PW-1:0]   ptr;
  logic            autoinc;
  logic [DW-1:0]   scratch;
  logic [DW-1:0]   rd_data;
  logic [RAMW-1:0] ram_q [DEPTH];
  logic [CW-1:0]   live_val [NCHAN];
  logic [CW-1:0]   snap_val [NCHAN];

  logic hit_ctrl, hit_info, hit_ptr, hit_data, hit_scratch, hit_ram;
  logic snap_req, clr_req;
  logic [PW-1:0]   ram_idx;
  logic [RAMW-1:0] ram_data_ptr, ram_data_dir;

  // Storage holds data XOR the power-up pattern, so an all-zero power-up
  // image presents the required initial contents without any reset.
  function automatic logic [RAMW-1:0] init_word(input logic [PW-1:0] a);
    return RAMW'(ram_init_byte(8'(a)));
  endfunction

  assign hit_ctrl    = gb_addr == AW'(OFF_CTRL);
  assign hit_info    = gb_addr == AW'(OFF_INFO);
  assign hit_ptr     = gb_addr == AW'(OFF_PTR);
  assign hit_data    = gb_addr == AW'(OFF_DATA);
  assign hit_scratch = gb_addr == AW'(OFF_SCRATCH);
  assign hit_ram     = gb_addr[AW-1:PW] == RAM_BASE[AW-1:PW];
  assign ram_idx     = gb_addr[PW-1:0];

  assign snap_req = gb_we && hit_ctrl && gb_din[CTRL_SNAP];
  assign clr_req  = gb_we && hit_ctrl && gb_din[CTRL_CLR];

  assign ram_data_ptr = ram_q[ptr] ^ init_word(ptr);
  assign ram_data_dir = ram_q[ram_idx] ^ init_word(ram_idx);

  always_comb begin
    rd_data = '0;
    if (hit_ctrl)         rd_data[CTRL_AUTOINC] = autoinc;
    else if (hit_info)    rd_data = DW'({8'(NCHAN), 8'(PW), 8'(CW), 8'(RAMW)});
    else if (hit_ptr)     rd_data = DW'(ptr);
    else if (hit_data)    rd_data = DW'(ram_data_ptr);
    else if (hit_scratch) rd_data = scratch;
    else if (hit_ram)     rd_data = DW'(ram_data_dir);
    for (int i = 0; i < NCHAN; i++) begin
      if (gb_addr == AW'(OFF_SNAP_BASE + i)) rd_data = DW'(snap_val[i]);
      if (gb_addr == AW'(OFF_LIVE_BASE + i)) rd_data = DW'(live_val[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gb_dout <= '0;
      ptr     <= '0;
      autoinc <= 1'b0;
      scratch <= SCRATCH_INIT;
    end else begin
      if (gb_re) gb_dout <= rd_data;
      if (gb_we && hit_ctrl) autoinc <= gb_din[CTRL_AUTOINC];
      if (gb_we && hit_scratch) scratch <= gb_din;
      if (gb_we && hit_ptr) ptr <= gb_din[PW-1:0];
      // A combined read+write on DATA still advances only once
      else if (hit_data && (gb_re || gb_we) && autoinc) ptr <= ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (gb_we && hit_data)     ram_q[ptr]     <= gb_din[RAMW-1:0] ^ init_word(ptr);
    else if (gb_we && hit_ram) ram_q[ram_idx] <= gb_din[RAMW-1:0] ^ init_word(ram_idx);
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    ha_event_counter #(.CW(CW)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .ev         (ev[c]),
      .clr        (clr_req),
      .snap       (snap_req),
      .count      (live_val[c]),
      .snap_count (snap_val[c])
    );
  end

endmodule

// File: tb/tb_ha_event_bank.sv
// tb/tb_ha_event_bank.sv - scoreboard bench for ha_event_bank (default build and CW=4 build)
module tb_ha_event_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ev = '0;
  logic [23:0] gb_addr = '0;
  logic [31:0] gb_din = '0;
  logic        gb_we = 1'b0;
  logic        gb_re = 1'b0;
  logic [31:0] dout, dout4;

  always #5 clk = ~clk;

  ha_event_bank dut (
    .clk(clk), .rst(rst), .ev(ev), .gb_addr(gb_addr), .gb_din(gb_din),
    .gb_we(gb_we), .gb_re(gb_re), .gb_dout(dout)
  );

  ha_event_bank #(.CW(4)) dut4 (
    .clk(clk), .rst(rst), .ev(ev), .gb_addr(gb_addr), .gb_din(gb_din),
    .gb_we(gb_we), .gb_re(gb_re), .gb_dout(dout4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] exp4_q[$];
  string       tag_q[$];
  logic        rd_pend = 1'b0;

  always @(posedge clk) rd_pend <= gb_re && !rst;

  always @(negedge clk) begin : mon
    string       t;
    logic [31:0] e, e4;
    if (rd_pend) begin
      if (tag_q.size() == 0) begin
        check_val("sb_underflow", 32'(tag_q.size()), 32'd1);
      end else begin
        t  = tag_q.pop_front();
        e  = exp_q.pop_front();
        e4 = exp4_q.pop_front();
        check_val({t, "_a"}, dout, e);
        check_val({t, "_cw4"}, dout4, e4);
      end
    end
  end

  task automatic push_exp(input logic [31:0] e, input logic [31:0] e4, input string tag);
    exp_q.push_back(e);
    exp4_q.push_back(e4);
    tag_q.push_back(tag);
  endtask

  task automatic bus_wr(input logic [23:0] a, input logic [31:0] d);
    @(negedge clk);
    gb_addr = a; gb_din = d; gb_we = 1'b1;
    @(negedge clk);
    gb_we = 1'b0;
  endtask

  task automatic bus_rd(input logic [23:0] a, input logic [31:0] e, input logic [31:0] e4,
                        input string tag);
    @(negedge clk);
    gb_addr = a; gb_re = 1'b1;
    push_exp(e, e4, tag);
    @(negedge clk);
    gb_re = 1'b0;
  endtask

  task automatic pulse(input int ch, input int n);
    repeat (n) begin
      @(negedge clk); ev[ch] = 1'b1;
      @(negedge clk); ev[ch] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_dout", dout, 32'h0);
    check_val("rst_dout4", dout4, 32'h0);
    rst = 1'b0;

    bus_rd(24'h004, 32'hceceface, 32'hceceface, "scratch_rst");
    bus_rd(24'h001, 32'h04061008, 32'h04060408, "info");
    bus_rd(24'h105, 32'h87, 32'h87, "ram_init5");

    // Snapshot of channel 2
    pulse(2, 3);
    bus_wr(24'h000, 32'h1);
    bus_rd(24'h012, 32'd3, 32'd3, "snap2");
    bus_rd(24'h010, 32'd0, 32'd0, "snap0");
    bus_rd(24'h022, 32'd3, 32'd3, "live2");
    bus_rd(24'h000, 32'd0, 32'd0, "ctrl_selfclr");

    // Saturation, then SNAP+CLR with a coincident edge
    pulse(0, 20);
    bus_rd(24'h020, 32'd20, 32'd15, "live0_sat");
    @(negedge clk);
    ev[0] = 1'b1; gb_addr = 24'h000; gb_din = 32'h3; gb_we = 1'b1;
    @(negedge clk);
    gb_we = 1'b0; ev[0] = 1'b0;
    bus_rd(24'h010, 32'd21, 32'd15, "snap0_clr");
    bus_rd(24'h020, 32'd0, 32'd0, "live0_clr");
    bus_rd(24'h012, 32'd3, 32'd3, "snap2_all");
    bus_rd(24'h022, 32'd0, 32'd0, "live2_clr");

    // CLR alone beats a coincident edge and leaves snapshots alone
    @(negedge clk);
    ev[1] = 1'b1; gb_addr = 24'h000; gb_din = 32'h2; gb_we = 1'b1;
    @(negedge clk);
    gb_we = 1'b0; ev[1] = 1'b0;
    bus_rd(24'h021, 32'd0, 32'd0, "live1_clr_wins");
    bus_rd(24'h010, 32'd21, 32'd15, "snap_hold");

    // LIVE read returns the value before the same-cycle edge
    @(negedge clk);
    ev[3] = 1'b1; gb_addr = 24'h023; gb_re = 1'b1;
    push_exp(32'd0, 32'd0, "live3_pre");
    @(negedge clk);
    gb_re = 1'b0; ev[3] = 1'b0;
    bus_rd(24'h023, 32'd1, 32'd1, "live3_post");

    bus_rd(24'h014, 32'd0, 32'd0, "snap_oob");
    bus_rd(24'h024, 32'd0, 32'd0, "live_oob");
    bus_rd(24'h005, 32'd0, 32'd0, "unmapped");

    // Pointer port with auto-increment and wrap
    bus_wr(24'h000, 32'h4);
    bus_wr(24'h002, 32'hffff_ff3e);
    bus_rd(24'h002, 32'h3e, 32'h3e, "ptr_mask");
    bus_wr(24'h003, 32'ha1);
    bus_wr(24'h003, 32'ha2);
    bus_wr(24'h003, 32'ha3);
    bus_rd(24'h002, 32'd1, 32'd1, "ptr_wrap");
    bus_rd(24'h13e, 32'ha1, 32'ha1, "ram62");
    bus_rd(24'h13f, 32'ha2, 32'ha2, "ram63");
    bus_rd(24'h100, 32'ha3, 32'ha3, "ram0");
    bus_rd(24'h000, 32'h4, 32'h4, "ctrl_autoinc");

    // DATA without auto-increment, then combined read+write
    bus_wr(24'h000, 32'h0);
    bus_wr(24'h002, 32'd5);
    bus_rd(24'h003, 32'h87, 32'h87, "data_rd1");
    bus_rd(24'h003, 32'h87, 32'h87, "data_rd2");
    bus_rd(24'h002, 32'd5, 32'd5, "ptr_still");
    bus_wr(24'h000, 32'h4);
    @(negedge clk);
    gb_addr = 24'h003; gb_din = 32'h5a; gb_we = 1'b1; gb_re = 1'b1;
    push_exp(32'h87, 32'h87, "data_rw_old");
    @(negedge clk);
    gb_we = 1'b0; gb_re = 1'b0;
    bus_rd(24'h002, 32'd6, 32'd6, "ptr_rw_inc");
    bus_rd(24'h105, 32'h5a, 32'h5a, "data_rw_stored");
    repeat (3) @(negedge clk);
    check_val("dout_hold", dout, 32'h5a);

    @(negedge clk);
    gb_addr = 24'h004; gb_din = 32'h12345678; gb_we = 1'b1; gb_re = 1'b1;
    push_exp(32'hceceface, 32'hceceface, "scratch_rw_old");
    @(negedge clk);
    gb_we = 1'b0; gb_re = 1'b0;
    bus_rd(24'h004, 32'h12345678, 32'h12345678, "scratch_new");

    // Reset in the middle of a read
    pulse(3, 1);
    @(negedge clk);
    gb_addr = 24'h004; gb_re = 1'b1;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_abort", dout, 32'h0);
    check_val("rst_abort4", dout4, 32'h0);
    @(negedge clk);
    gb_re = 1'b0; rst = 1'b0;
    bus_rd(24'h004, 32'hceceface, 32'hceceface, "scratch_restored");
    bus_rd(24'h023, 32'd0, 32'd0, "live3_rst");
    bus_rd(24'h010, 32'd0, 32'd0, "snap0_rst");
    bus_rd(24'h002, 32'd0, 32'd0, "ptr_rst");
    bus_rd(24'h000, 32'd0, 32'd0, "ctrl_rst");
    bus_rd(24'h13e, 32'ha1, 32'ha1, "ram_kept62");
    bus_rd(24'h105, 32'h5a, 32'h5a, "ram_kept5");

    repeat (2) @(negedge clk);
    check_val("sb_drain", 32'(tag_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
